// File: rtl/pulse_event_queue.sv
// -----------------------------------------------------------------------------
// pulse_event_queue
//
// Purpose:
//   Collects single-cycle event pulses from the rising-edge detector bank
//   (player keys, shot, collision and timer events). It serialises them into
//   an ordered queue of event IDs for the game-state controller.
//   Each incoming pulse is latched in a pending bit. A fixed-priority arbiter
//   (lowest index wins) grants one pending source per cycle into a
//   first-word-fall-through FIFO. The FIFO is drained through a valid/ready
//   handshake.
//
// Parameters:
//   NUM_SRC  number of pulse sources (2..31)
//   DEPTH    FIFO entries (power of 2, >= 2)
//   ID_W     event ID width (2**ID_W >= NUM_SRC)
//
// Ports:
//   clk          system clock, rising edge
//   resetN       asynchronous active-low reset
//   pulse_in     one-cycle event pulses, bit i = source i
//   event_ready  consumer accepts the head entry this cycle
//   event_valid  FIFO holds at least one entry
//   event_id     source index at the FIFO head, 0 when event_valid = 0
//   fifo_count   number of FIFO entries, 0..DEPTH
//   pending      sources latched but not yet written to the FIFO
//   drop_cnt     merged-pulse counter, saturates at 255
//
// Handshake:
//   An entry transfers when event_valid and event_ready are both 1 on a
//   rising clock edge. event_id is stable while event_valid is 1 and
//   event_ready is 0. event_ready may be high while event_valid is 0; that
//   cycle is ignored.
// -----------------------------------------------------------------------------
module pulse_event_queue #(
   parameter int NUM_SRC = 17,
   parameter int DEPTH   = 8,
   parameter int ID_W    = 5
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic [NUM_SRC-1:0]         pulse_in,
   input  logic                       event_ready,
   output logic                       event_valid,
   output logic [ID_W-1:0]            event_id,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [NUM_SRC-1:0]         pending,
   output logic [7:0]                 drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_SRC-1:0] pending_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [7:0]         drop_q;
   logic [ID_W-1:0]    mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------------
   logic               pop;
   logic               can_push;
   logic               push;
   logic [NUM_SRC-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic [NUM_SRC-1:0] merged;
   logic [8:0]         merged_cnt;
   logic [8:0]         drop_sum;
   logic [7:0]         drop_d;
   logic [CNT_W-1:0]   count_d;
   logic [NUM_SRC-1:0] pending_d;

   assign event_valid = (count_q != '0);
   assign pop         = event_valid & event_ready;
   // A pop in the same cycle frees the slot the push lands in. A full FIFO
   // with a draining consumer therefore keeps full throughput.
   assign can_push    = (count_q < FULL_CNT) | pop;
   assign push        = (pending_q != '0) & can_push;

   // Lowest-set-bit isolation: x & (~x + 1) leaves only the lowest 1.
   // The arbiter looks at the registered pending bits only, never at
   // pulse_in.
   always_comb begin
      grant = '0;
      if (push) begin
         grant = pending_q & (~pending_q + NUM_SRC'(1));
      end
   end

   // Binary index of the lowest pending source. Scanning from the top down
   // leaves the lowest index as the final assignment.
   always_comb begin
      grant_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            grant_idx = ID_W'(i);
         end
      end
   end

   // Set wins over clear. A source pulsing in its own grant cycle stays
   // pending and produces a second event.
   assign pending_d = (pending_q & ~grant) | pulse_in;

   // A pulse on a source that is already pending and not being granted
   // folds into the existing event. Each such bit counts once.
   assign merged = pulse_in & pending_q & ~grant;

   always_comb begin
      merged_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         merged_cnt = merged_cnt + 9'(merged[i]);
      end
   end

   // merged_cnt <= 31, so the 9-bit sum cannot overflow before the
   // saturation check.
   assign drop_sum = {1'b0, drop_q} + merged_cnt;
   assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         drop_q    <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Storage has no reset. Entries are only read when fifo_count says they
   // were written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= grant_idx;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign event_id   = event_valid ? mem[rd_ptr_q] : '0;
   assign fifo_count = count_q;
   assign pending    = pending_q;
   assign drop_cnt   = drop_q;

endmodule

// File: doc/pulse_event_queue.md
# pulse_event_queue

Collects single-cycle event pulses from the bank of rising-edge detectors (player keys, shot, collision and timer events) and serialises them into an ordered queue of event IDs for the game controller. Simultaneous pulses are never lost: each is held pending until granted by a fixed-priority arbiter, written into a first-word-fall-through FIFO, and popped through a valid/ready handshake. It sits directly downstream of the edge-detector stage and upstream of the game-state controller.

## Interface
- NUM_SRC, 17, number of pulse sources; legal range 2..31.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- ID_W, 5, event ID width; must satisfy 2^ID_W >= NUM_SRC.
- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- pulse_in  in  NUM_SRC  one-cycle event pulses; bit i is source i.
- event_ready  in  1  consumer accepts the head entry this cycle.
- event_valid  out  1  FIFO holds at least one entry.
- event_id  out  ID_W  source index at the FIFO head; forced to 0 when event_valid=0.
- fifo_count  out  clog2(DEPTH)+1  number of entries in the FIFO, 0..DEPTH.
- pending  out  NUM_SRC  sources latched but not yet written to the FIFO.
- drop_cnt  out  8  merged-pulse counter; saturates at 255.

## Operation
- Pending register update: pending <= (pending & ~grant) | pulse_in.
  - If a source's pulse arrives in the same cycle that source is granted, the set wins and the bit stays 1. This yields a second event.
- Grant:
  - pop = event_valid & event_ready.
  - can_push = (fifo_count < DEPTH) | pop.
  - If pending != 0 and can_push, grant is one-hot on the lowest-index set bit of pending. Otherwise grant = 0.
  - Grant is taken from the registered pending only, never directly from pulse_in.
- Push: on grant, the granted index is written at the write pointer, and the write pointer advances modulo DEPTH.
- Pop: advances the read pointer modulo DEPTH. event_id always shows the entry at the read pointer.
- fifo_count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when full.
- Merging: a pulse_in bit i that arrives while pending[i]=1 and i is not granted this cycle is merged (no new event) and increments drop_cnt. drop_cnt increments once per merged bit; several merged bits in the same cycle add their sum. drop_cnt saturates at 255.
- Pop while event_valid=0 is ignored.
- Pointers wrap silently. Full and empty are decided by fifo_count alone.
- FIFO memory needs no reset. All other state resets.

## Timing
- Reset values: event_valid=0, event_id=0, fifo_count=0, pending=0, drop_cnt=0, both pointers 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). All queued and pending events are discarded.
- Latency on an idle, empty queue:
  - Pulse in cycle 0.
  - pending[i]=1 in cycle 1; the grant happens in cycle 1.
  - event_valid=1 with event_id=i in cycle 2.
- Throughput: one push and one pop per cycle. N simultaneous pulses appear on consecutive cycles 2..N+1 when event_ready is held at 1.
- With event_ready=1 continuously, each entry stays at the head for exactly one cycle.
- With the FIFO full and no pop, grants stall, and pending holds without loss apart from merging.

## Test plan
- Reset: assert resetN=0 mid-burst. All outputs read 0 in the same cycle and stay 0 after release with no pulses.
- Single event: pulse_in[3] in cycle 0, event_ready=1. event_valid=1, event_id=3 in cycle 2 only; fifo_count returns to 0 in cycle 3.
- Simultaneous: pulse_in bits 16, 5 and 0 in cycle 0, event_ready=1. event_id shows 0, 5, 16 in cycles 2, 3, 4; drop_cnt=0.
- Backpressure: event_ready=0, pulses on sources 0..9 in cycle 0.
  - fifo_count reaches 8 by cycle 9, and pending=10'b11_0000_0000 thereafter.
  - Raise event_ready: IDs 0..9 drain in order. The 9th ID appears with no gap cycle.
- Merge and saturation: event_ready=0, FIFO full, pending[7]=1, then pulse source 7 for 300 separate cycles. drop_cnt reads 255; exactly one ID 7 appears after draining.
- Set-wins: pulse source 2 in cycle 0 and again in cycle 1, which is its grant cycle, with event_ready=1. ID 2 appears in cycle 2 and again in cycle 3; drop_cnt=0.
